// File: rtl/dma_ring_ctrl_pkg.sv
// rtl/dma_ring_ctrl_pkg.sv - shared FSM states, defaults and min/saturation helpers
package dma_ring_ctrl_pkg;

  // Default geometry of the capture path
  localparam int DEF_DATA_BITS   = 64;
  localparam int DEF_ADDR_BITS   = 32;
  localparam int DEF_LENGTH_BITS = 16;

  // Ring sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_ADV   = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // Unsigned minimum; callers widen/truncate around it
  function automatic logic [31:0] umin(input logic [31:0] a, input logic [31:0] b);
    return (a < b) ? a : b;
  endfunction

  // a - b clamped at zero
  function automatic logic [31:0] sat0_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/dma_ring_seg_calc.sv
// rtl/dma_ring_seg_calc.sv - next segment length and destination byte address
module dma_ring_seg_calc
  import dma_ring_ctrl_pkg::*;
#(
  parameter int AddrBits     = DEF_ADDR_BITS,
  parameter int LengthBits   = DEF_LENGTH_BITS,
  parameter int BytesPerWord = DEF_DATA_BITS / 8
) (
  input  logic [AddrBits-1:0]   base,
  input  logic [LengthBits-1:0] ring_words,
  input  logic [LengthBits-1:0] chunk_words,
  input  logic [LengthBits-1:0] wr_ptr,
  input  logic [LengthBits-1:0] post_left,
  input  logic                  triggered,
  output logic [LengthBits-1:0] seg,
  output logic [AddrBits-1:0]   dest
);

  localparam int Shift = $clog2(BytesPerWord);

  logic [LengthBits-1:0] room;
  logic [LengthBits-1:0] limit;
  logic [AddrBits-1:0]   offset;

  // Segment never crosses the ring end and, once triggered, never exceeds the post budget
  always_comb begin
    room   = ring_words - wr_ptr;
    limit  = triggered ? post_left : chunk_words;
    seg    = LengthBits'(umin(umin(32'(chunk_words), 32'(room)), 32'(limit)));
    offset = AddrBits'(wr_ptr) << Shift;
    dest   = base + offset;
  end

endmodule

// File: rtl/dma_ring_ctrl.sv
// rtl/dma_ring_ctrl.sv - sequences a dma_writer to capture a stream into a memory ring
module dma_ring_ctrl
  import dma_ring_ctrl_pkg::*;
#(
  parameter int DataBits   = DEF_DATA_BITS,
  parameter int AddrBits   = DEF_ADDR_BITS,
  parameter int LengthBits = DEF_LENGTH_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctl_start,
  input  logic                  ctl_stop,
  input  logic [AddrBits-1:0]   ctl_base,
  input  logic [LengthBits-1:0] ctl_ring_words,
  input  logic [LengthBits-1:0] ctl_chunk_words,
  input  logic [4:0]            ctl_burst,
  input  logic [LengthBits-1:0] ctl_post_words,
  input  logic                  trig,
  output logic [AddrBits-1:0]   dma_dest,
  output logic [LengthBits-1:0] dma_len,
  output logic [4:0]            dma_burst,
  output logic                  dma_valid,
  input  logic                  dma_busy,
  input  logic                  dma_done,
  input  logic [LengthBits-1:0] dma_remain,
  input  logic [1:0]            dma_err,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [LengthBits-1:0] sts_wr_ptr,
  output logic                  sts_wrapped,
  output logic                  sts_triggered,
  output logic [LengthBits-1:0] sts_trig_ptr,
  output logic [1:0]            sts_err,
  output logic                  sts_bad_cfg
);

  localparam int BytesPerWord = DataBits / 8;

  state_t                state;
  logic [AddrBits-1:0]   base_q;
  logic [LengthBits-1:0] ring_q;
  logic [LengthBits-1:0] chunk_q;
  logic [LengthBits-1:0] post_q;
  logic [LengthBits-1:0] seg;
  logic [LengthBits-1:0] post_left;
  logic                  stop_pend;
  logic                  trig_this_seg;
  logic [1:0]            seg_err;

  logic [LengthBits-1:0] calc_seg;
  logic [AddrBits-1:0]   calc_dest;
  logic [LengthBits-1:0] rem_eff;
  logic [LengthBits:0]   tp_sum;
  logic [LengthBits:0]   tp_mod;
  logic [LengthBits:0]   adv_sum;
  logic                  adv_wrap;
  logic [LengthBits-1:0] post_after_trig;

  dma_ring_seg_calc #(
    .AddrBits    (AddrBits),
    .LengthBits  (LengthBits),
    .BytesPerWord(BytesPerWord)
  ) u_seg_calc (
    .base       (base_q),
    .ring_words (ring_q),
    .chunk_words(chunk_q),
    .wr_ptr     (sts_wr_ptr),
    .post_left  (post_left),
    .triggered  (sts_triggered),
    .seg        (calc_seg),
    .dest       (calc_dest)
  );

  // Trigger position and post budget; a trigger coincident with done sees nothing remaining
  always_comb begin
    rem_eff         = dma_done ? '0 : LengthBits'(umin(32'(dma_remain), 32'(seg)));
    tp_sum          = {1'b0, sts_wr_ptr} + {1'b0, seg} - {1'b0, rem_eff};
    tp_mod          = (tp_sum >= {1'b0, ring_q}) ? (tp_sum - {1'b0, ring_q}) : tp_sum;
    post_after_trig = LengthBits'(sat0_sub(32'(post_q), 32'(rem_eff)));
    adv_sum         = {1'b0, sts_wr_ptr} + {1'b0, seg};
    adv_wrap        = (adv_sum == {1'b0, ring_q});
  end

  // Capture sequencer with registered status and dma_writer command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      ring_q        <= '0;
      chunk_q       <= '0;
      post_q        <= '0;
      seg           <= '0;
      post_left     <= '0;
      stop_pend     <= 1'b0;
      trig_this_seg <= 1'b0;
      seg_err       <= '0;
      dma_dest      <= '0;
      dma_len       <= '0;
      dma_burst     <= '0;
      dma_valid     <= 1'b0;
      sts_busy      <= 1'b0;
      sts_done      <= 1'b0;
      sts_wr_ptr    <= '0;
      sts_wrapped   <= 1'b0;
      sts_triggered <= 1'b0;
      sts_trig_ptr  <= '0;
      sts_err       <= '0;
      sts_bad_cfg   <= 1'b0;
    end else begin
      sts_done <= 1'b0;
      if (sts_busy && ctl_stop) begin
        stop_pend <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ctl_start) begin
            if (ctl_ring_words == '0 || ctl_chunk_words == '0) begin
              sts_bad_cfg <= 1'b1;
              sts_done    <= 1'b1;
            end else begin
              base_q        <= ctl_base;
              ring_q        <= ctl_ring_words;
              chunk_q       <= ctl_chunk_words;
              post_q        <= ctl_post_words;
              dma_burst     <= ctl_burst;
              post_left     <= '0;
              stop_pend     <= 1'b0;
              sts_wr_ptr    <= '0;
              sts_wrapped   <= 1'b0;
              sts_triggered <= 1'b0;
              sts_trig_ptr  <= '0;
              sts_err       <= '0;
              sts_bad_cfg   <= 1'b0;
              sts_busy      <= 1'b1;
              state         <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (calc_seg == '0) begin
            state <= ST_FIN;
          end else begin
            seg           <= calc_seg;
            dma_len       <= calc_seg;
            dma_dest      <= calc_dest;
            dma_valid     <= 1'b1;
            trig_this_seg <= 1'b0;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dma_busy) begin
            dma_valid <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (trig && !sts_triggered) begin
            sts_triggered <= 1'b1;
            trig_this_seg <= 1'b1;
            sts_trig_ptr  <= tp_mod[LengthBits-1:0];
            post_left     <= post_after_trig;
          end
          if (dma_done) begin
            seg_err <= dma_err;
            state   <= ST_ADV;
          end
        end
        ST_ADV: begin
          sts_wr_ptr <= adv_wrap ? '0 : adv_sum[LengthBits-1:0];
          if (adv_wrap) begin
            sts_wrapped <= 1'b1;
          end
          // The trigger segment's tail was already charged against the budget
          if (sts_triggered && !trig_this_seg) begin
            post_left <= post_left - LengthBits'(umin(32'(post_left), 32'(seg)));
          end
          if (seg_err != '0 && sts_err == '0) begin
            sts_err <= seg_err;
          end
          state <= (stop_pend || ctl_stop || seg_err != '0) ? ST_FIN : ST_CALC;
        end
        ST_FIN: begin
          sts_done <= 1'b1;
          sts_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
